state_poly_tomsg: RTL and testbench
===================================

Name: state_poly_tomsg

Overview:
- Inverse of the poly_frommsg stage: reads a 256-coefficient polynomial from a coefficient RAM and packs the 1-bit Kyber compression of each coefficient into a 32-byte message.
- Used in decryption to recover the message from v - s^T u.
- Acts as the read initiator toward a one-cycle-latency polynomial RAM.
- Presents the packed message as a flat 256-bit vector with a done pulse and a valid level.

Parameters:
- KYBER_Q, 3329, modulus.
- KYBER_N, 256, coefficients per polynomial.
- KYBER_SYMBYTES, 32, message bytes.
- Byte_bits, 8, bits per byte.
- Length, 12, coefficient width.
- Msg_size, KYBER_SYMBYTES*Byte_bits, message width.
- Lo_Th, 833, lowest coefficient that compresses to 1.
- Hi_Th, 2496, highest coefficient that compresses to 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low; clock clk.
- enable  in  1  start request, sampled in IDLE only.
- iPoly_Data  in  Length  RAM read data; valid the cycle after the address is presented.
- rd_en  out  1  RAM read strobe.
- Poly_Ad  out  8  RAM read address.
- busy  out  1  high from the accept edge until the return to IDLE.
- Function_Done  out  1  one-cycle pulse when the message is complete.
- oMsg_valid  out  1  level; oMsg_byte_array holds a complete result.
- oMsg_byte_array  out  Msg_size  packed message; coefficient i maps to bit i (byte i/8, bit i%8).

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; rd_en, busy, Function_Done, oMsg_valid = 0; Poly_Ad = 0; oMsg_byte_array = 0; internal pipeline valid bit cleared.
- Reset mid-operation: aborts immediately to the same values; no Function_Done is produced.
- States:
  - IDLE: on enable=1, go to READ; rd_en<=1; Poly_Ad<=0; busy<=1; oMsg_valid<=0.
  - READ: Poly_Ad increments each cycle with rd_en=1. The edge issuing address 255 is followed by the edge that moves to DRAIN with rd_en<=0.
  - DRAIN: one cycle; the returning data for address 255 is written; go to DONE; Function_Done<=1.
  - DONE: one cycle; Function_Done<=0, oMsg_valid<=1, busy<=0; go to IDLE.
- Pipeline: rd_en and Poly_Ad are delayed one cycle (v_d, a_d). On every edge with v_d=1, msg[a_d] <= compressed bit of iPoly_Data.
- Compression, with x = iPoly_Data:
  - Reduce once: x' = x-KYBER_Q if x >= KYBER_Q, else x.
  - bit = 1 iff Lo_Th <= x' <= Hi_Th.
  - This is equivalent to ((2x'+Q/2)/Q)&1.
  - No divider or modulo operator is used.
- Timing, with the enable-accept edge as E0:
  - Address k is on Poly_Ad during the cycle after edge E0+k.
  - The final bit is written at E0+257.
  - Function_Done is high for exactly one cycle after edge E0+257.
  - oMsg_valid rises at E0+258.
- Enable while not in IDLE is ignored. Enable held high in IDLE after DONE starts a new run immediately and clears oMsg_valid.
- oMsg_byte_array bits not yet rewritten keep their previous-run values during a run. They are only meaningful while oMsg_valid=1.
- Poly_Ad is held at its last value when rd_en=0; the RAM ignores it.

Test Plan:
- RAM all 0 -> oMsg_byte_array = 0. Function_Done pulses exactly once, in the cycle after E0+257. rd_en is high for exactly 256 cycles with addresses 0..255 in order.
- RAM all 1665 -> oMsg_byte_array = all ones; oMsg_valid=1 and stays high until the next enable.
- Threshold set, in coefficients 0..7 with the rest 0:
  - Values 832, 833, 2496, 2497, 3328, 0, 1665, 3330.
  - Required: byte 0 = 8'b0100_0110.
  - Byte 0 reads MSB..LSB as coeff 7..0: 832 ->0, 833 ->1, 2496 ->1, 2497 ->0, 3328 ->0, 0 ->0, 1665 ->1, 3330 (non-canonical, reduces to 1) ->0.
- Round trip: random 32-byte msg -> poly_frommsg writes RAM -> this block reads it back -> output equals msg bit-exact. Repeat for 100 random messages with 0/±400 noise added to each coefficient mod Q.
- Enable pulsed during READ at address 100 -> no restart; addresses continue 101..255 and exactly one Function_Done occurs.
- rst_n low for one cycle at address 150 -> next cycle rd_en=0, busy=0, Poly_Ad=0, oMsg=0, no Function_Done. A following enable completes a normal run with the correct result.

Source files
------------

// File: rtl/state_poly_tomsg_if.sv
// rtl/state_poly_tomsg_if.sv - start/RAM-read/result bundle for state_poly_tomsg
interface state_poly_tomsg_if #(
    parameter int Length   = 12,
    parameter int Msg_size = 256
);
    logic                enable;
    logic [Length-1:0]   iPoly_Data;
    logic                rd_en;
    logic [7:0]          Poly_Ad;
    logic                busy;
    logic                Function_Done;
    logic                oMsg_valid;
    logic [Msg_size-1:0] oMsg_byte_array;

    // master is the packing block (read initiator); slave is the RAM/controller side
    modport master (
        input  enable,
        input  iPoly_Data,
        output rd_en,
        output Poly_Ad,
        output busy,
        output Function_Done,
        output oMsg_valid,
        output oMsg_byte_array
    );

    modport slave (
        output enable,
        output iPoly_Data,
        input  rd_en,
        input  Poly_Ad,
        input  busy,
        input  Function_Done,
        input  oMsg_valid,
        input  oMsg_byte_array
    );
endinterface

// File: rtl/state_poly_tomsg.sv
// rtl/state_poly_tomsg.sv - reads 256 coefficients and packs their 1-bit compression into a 32-byte message
module state_poly_tomsg #(
    parameter int KYBER_Q        = 3329,
    parameter int KYBER_N        = 256,
    parameter int KYBER_SYMBYTES = 32,
    parameter int Byte_bits      = 8,
    parameter int Length         = 12,
    parameter int Msg_size       = KYBER_SYMBYTES * Byte_bits,
    parameter int Lo_Th          = 833,
    parameter int Hi_Th          = 2496
) (
    input  logic               clk,
    input  logic               rst_n,
    state_poly_tomsg_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    localparam logic [7:0]        LAST_AD = 8'(KYBER_N - 1);
    localparam logic [Length-1:0] Q_L     = Length'(KYBER_Q);
    localparam logic [Length-1:0] LO_L    = Length'(Lo_Th);
    localparam logic [Length-1:0] HI_L    = Length'(Hi_Th);

    state_t              state_q, state_d;
    logic                rd_en_q, rd_en_d;
    logic [7:0]          ad_q, ad_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                valid_q, valid_d;
    logic                v_dly_q, v_dly_d;
    logic [7:0]          a_dly_q, a_dly_d;
    logic [Msg_size-1:0] msg_q, msg_d;

    logic [Length-1:0]   x_red;
    logic                coeff_bit;

    // One conditional subtract covers any 12-bit input below 2Q; the threshold window replaces the rounding divide
    always_comb begin
        x_red = bus.iPoly_Data;
        if (bus.iPoly_Data >= Q_L) begin
            x_red = bus.iPoly_Data - Q_L;
        end
        coeff_bit = (x_red >= LO_L) && (x_red <= HI_L);
    end

    always_comb begin
        state_d = state_q;
        rd_en_d = rd_en_q;
        ad_d    = ad_q;
        busy_d  = busy_q;
        done_d  = done_q;
        valid_d = valid_q;
        v_dly_d = rd_en_q;
        a_dly_d = ad_q;
        msg_d   = msg_q;
        // RAM data arrives one cycle after its address, so writes follow the delayed strobe/address
        if (v_dly_q) begin
            msg_d[a_dly_q] = coeff_bit;
        end
        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d = READ;
                    rd_en_d = 1'b1;
                    ad_d    = 8'd0;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                end
            end
            READ: begin
                if (ad_q == LAST_AD) begin
                    state_d = DRAIN;
                    rd_en_d = 1'b0;
                end else begin
                    ad_d = ad_q + 8'd1;
                end
            end
            DRAIN: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b0;
                valid_d = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rd_en_q <= 1'b0;
            ad_q    <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            v_dly_q <= 1'b0;
            a_dly_q <= 8'd0;
            msg_q   <= '0;
        end else begin
            state_q <= state_d;
            rd_en_q <= rd_en_d;
            ad_q    <= ad_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            v_dly_q <= v_dly_d;
            a_dly_q <= a_dly_d;
            msg_q   <= msg_d;
        end
    end

    assign bus.rd_en           = rd_en_q;
    assign bus.Poly_Ad         = ad_q;
    assign bus.busy            = busy_q;
    assign bus.Function_Done   = done_q;
    assign bus.oMsg_valid      = valid_q;
    assign bus.oMsg_byte_array = msg_q;
endmodule

// File: tb/tb_state_poly_tomsg.sv
// tb/tb_state_poly_tomsg.sv - self-checking bench for state_poly_tomsg with a timeline model and RAM model
module tb_state_poly_tomsg;
    localparam int Q = 3329;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    state_poly_tomsg_if #(.Length(12), .Msg_size(256)) bus();

    state_poly_tomsg dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [11:0] ram [256];

    always @(posedge clk) begin
        if (bus.rd_en) bus.iPoly_Data <= ram[bus.Poly_Ad];
    end

    function automatic logic exp_bit(input int x);
        int r;
        r = x % Q;
        return (((2 * r + Q / 2) / Q) % 2) == 1;
    endfunction

    // phase = edges since the accept edge; -1 = idle since reset; -2 = not yet reset
    int           phase = -2;
    logic [255:0] exp_msg;
    int           done_cnt = 0;
    int           rd_cnt = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            phase   = -1;
            exp_msg = '0;
        end else if ((phase == -1 || phase >= 258) && bus.enable) begin
            phase = 0;
            for (int i = 0; i < 256; i++) exp_msg[i] = exp_bit(int'(ram[i]));
        end else if (phase >= 0) begin
            phase++;
        end
    end

    logic [11:0] got_c, want_c;
    logic        w_rd, w_busy, w_done, w_valid;
    logic [7:0]  w_ad;

    always @(negedge clk) begin
        if (phase >= -1) begin
            w_rd    = (phase >= 0 && phase <= 255);
            w_busy  = (phase >= 0 && phase <= 257);
            w_done  = (phase == 257);
            w_valid = (phase >= 258);
            if (phase == -1)     w_ad = 8'd0;
            else if (phase <= 255) w_ad = 8'(phase);
            else                 w_ad = 8'd255;
            want_c = {w_rd, w_busy, w_done, w_valid, w_ad};
            got_c  = {bus.rd_en, bus.busy, bus.Function_Done, bus.oMsg_valid, bus.Poly_Ad};
            checks++;
            if (got_c !== want_c) begin
                errors++;
                $display("FAIL ctrl phase=%0d got {rd,busy,done,valid,ad}=%h want=%h", phase, got_c, want_c);
            end
            if (phase == -1 || phase >= 258) begin
                checks++;
                if (bus.oMsg_byte_array !== exp_msg) begin
                    errors++;
                    $display("FAIL msg phase=%0d got=%h want=%h", phase, bus.oMsg_byte_array, exp_msg);
                end
            end
            if (bus.Function_Done === 1'b1) done_cnt++;
            if (bus.rd_en === 1'b1) rd_cnt++;
        end
    end

    task automatic expect_eq(input string name, input logic [255:0] got, input logic [255:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic run(input int pulse_ad, input int rst_ad, output bit ok);
        int rst_seen;
        rst_seen = -1;
        ok       = 1'b0;
        done_cnt = 0;
        rd_cnt   = 0;
        @(negedge clk);
        bus.enable = 1'b1;
        @(negedge clk);
        bus.enable = 1'b0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clk);
            bus.enable = 1'b0;
            rst_n      = 1'b1;
            if (rst_seen >= 0) begin
                if (c - rst_seen >= 3) ok = 1'b1;
            end else if (bus.oMsg_valid === 1'b1) begin
                ok = 1'b1;
            end else if (bus.rd_en === 1'b1 && int'(bus.Poly_Ad) == pulse_ad) begin
                bus.enable = 1'b1;
            end else if (bus.rd_en === 1'b1 && int'(bus.Poly_Ad) == rst_ad) begin
                rst_n    = 1'b0;
                rst_seen = c;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL run_timeout got=no_completion want=completion_within_400_cycles");
        end
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < 256; i++) ram[i] = 12'(v);
    endtask

    bit           ok;
    logic [255:0] rmsg;
    int           nz, v;
    logic [11:0]  thr [8];

    initial begin
        thr[0] = 12'd832;  thr[1] = 12'd833;  thr[2] = 12'd2496; thr[3] = 12'd2497;
        thr[4] = 12'd3328; thr[5] = 12'd0;    thr[6] = 12'd1665; thr[7] = 12'd3330;
        rst_n      = 1'b0;
        bus.enable = 1'b0;
        fill(0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expect_eq("reset_msg", bus.oMsg_byte_array, '0);
        expect_eq("reset_valid", {255'd0, bus.oMsg_valid}, '0);

        run(-1, -1, ok);
        expect_eq("zero_msg", bus.oMsg_byte_array, '0);
        expect_eq("zero_done_count", 256'(done_cnt), 256'd1);
        expect_eq("zero_rd_cycles", 256'(rd_cnt), 256'd256);

        fill(1665);
        run(-1, -1, ok);
        expect_eq("half_q_msg", bus.oMsg_byte_array, {256{1'b1}});
        repeat (20) @(negedge clk);
        expect_eq("valid_held", {255'd0, bus.oMsg_valid}, 256'd1);

        fill(0);
        for (int i = 0; i < 8; i++) ram[i] = thr[i];
        run(-1, -1, ok);
        expect_eq("threshold_byte0", {248'd0, bus.oMsg_byte_array[7:0]}, {248'd0, 8'b0100_0110});
        expect_eq("threshold_rest", {8'd0, bus.oMsg_byte_array[255:8]}, '0);

        // enable held across the end of a run restarts immediately
        fill(1665);
        done_cnt = 0;
        @(negedge clk);
        bus.enable = 1'b1;
        repeat (300) @(negedge clk);
        bus.enable = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clk);
            if (bus.oMsg_valid === 1'b1) ok = 1'b1;
        end
        expect_eq("held_enable_done_count", 256'(done_cnt), 256'd2);

        fill(0);
        for (int i = 0; i < 8; i++) ram[i] = thr[i];
        run(100, -1, ok);
        expect_eq("pulse_done_count", 256'(done_cnt), 256'd1);
        expect_eq("pulse_rd_cycles", 256'(rd_cnt), 256'd256);
        expect_eq("pulse_msg", bus.oMsg_byte_array, {248'd0, 8'b0100_0110});

        fill(1665);
        run(-1, 150, ok);
        expect_eq("abort_done_count", 256'(done_cnt), 256'd0);
        expect_eq("abort_msg", bus.oMsg_byte_array, '0);
        expect_eq("abort_busy", {255'd0, bus.busy}, '0);
        run(-1, -1, ok);
        expect_eq("after_abort_msg", bus.oMsg_byte_array, {256{1'b1}});

        for (int t = 0; t < 100; t++) begin
            for (int w = 0; w < 8; w++) rmsg[w*32 +: 32] = $urandom;
            for (int i = 0; i < 256; i++) begin
                nz = int'($urandom_range(0, 2));
                v  = rmsg[i] ? 1665 : 0;
                if (nz == 1) v = v + 400;
                if (nz == 2) v = v + Q - 400;
                ram[i] = 12'(v % Q);
            end
            run(-1, -1, ok);
            expect_eq("round_trip", bus.oMsg_byte_array, rmsg);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
